// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the load/store unit: funct3 width encodings,
// LSU state type and an access-legality helper.
package rv32i_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_DONE = 2'd2
   } lsu_state_e;

   // True when funct3 is legal for the direction and the lane is naturally aligned.
   function automatic logic lsu_access_ok(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] lane);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = (lane[0] == 1'b0);
         F3_W:    ok = (lane == 2'b00);
         F3_BU:   ok = !is_store;
         F3_HU:   ok = !is_store && (lane[0] == 1'b0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/rv32i_lsu_if.sv
// Data-memory req/ack bus between the LSU (master) and memory (slave).
interface rv32i_lsu_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/rv32i_load_align.sv
// Combinational load extraction: selects the byte/half lane and sign- or zero-extends.
module rv32i_load_align
   import rv32i_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = mem_rdata[7:0];
      case (lane)
         2'd0: byte_v = mem_rdata[7:0];
         2'd1: byte_v = mem_rdata[15:8];
         2'd2: byte_v = mem_rdata[23:16];
         2'd3: byte_v = mem_rdata[31:24];
         default: byte_v = mem_rdata[7:0];
      endcase
      half_v = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      result = '0;
      case (funct3)
         F3_B:    result = {{24{byte_v[7]}}, byte_v};
         F3_H:    result = {{16{half_v[15]}}, half_v};
         F3_W:    result = mem_rdata;
         F3_BU:   result = {24'h0, byte_v};
         F3_HU:   result = {16'h0, half_v};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one data-memory transaction per start, with
// alignment/funct3 fault detection, ack timeout and register-file write-back.
module rv32i_lsu
   import rv32i_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        sys_clk,
   input  logic        sys_reset,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] base,
   input  logic [31:0] offset,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic        rd_we,
   output logic [31:0] rd_data,
   rv32i_lsu_if.master bus
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

   lsu_state_e  state_q, state_d;
   logic [7:0]  tmo_q, tmo_d;
   logic        fault_q, fault_d;
   logic        accept, capture;

   logic        op_store_q;
   logic [2:0]  op_f3_q;
   logic [1:0]  lane_q;
   logic [31:0] addr_q, wdata_q, rd_data_q;
   logic [3:0]  wstrb_q;

   logic [31:0] ea, st_wdata, ld_result;
   logic [3:0]  st_wstrb;
   logic        access_ok;

   assign ea        = base + offset;
   assign access_ok = lsu_access_ok(is_store, funct3, ea[1:0]);

   // Lane replication and strobes are resolved at accept so the bus stays stable in REQ.
   always_comb begin
      st_wdata = store_data;
      st_wstrb = '0;
      if (is_store) begin
         case (funct3)
            F3_B: begin
               st_wdata = {4{store_data[7:0]}};
               st_wstrb = 4'b0001 << ea[1:0];
            end
            F3_H: begin
               st_wdata = {2{store_data[15:0]}};
               st_wstrb = 4'b0011 << ea[1:0];
            end
            default: st_wstrb = '1;
         endcase
      end
   end

   rv32i_load_align u_align (
      .mem_rdata (bus.mem_rdata),
      .lane      (lane_q),
      .funct3    (op_f3_q),
      .result    (ld_result)
   );

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      fault_d = fault_q;
      accept  = 1'b0;
      capture = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (start) begin
               accept = 1'b1;
               tmo_d  = '0;
               if (access_ok) begin
                  state_d = LSU_REQ;
                  fault_d = 1'b0;
               end else begin
                  state_d = LSU_DONE;
                  fault_d = 1'b1;
               end
            end
         end
         LSU_REQ: begin
            if (bus.mem_ack) begin
               state_d = LSU_DONE;
               fault_d = 1'b0;
               capture = !op_store_q;
            end else if (tmo_q + 8'd1 == TMO_LIMIT) begin
               state_d = LSU_DONE;
               fault_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         LSU_DONE: state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase

      busy          = (state_q != LSU_IDLE);
      done          = (state_q == LSU_DONE);
      fault         = done && fault_q;
      rd_we         = done && !fault_q && !op_store_q;
      rd_data       = rd_data_q;
      bus.mem_req   = (state_q == LSU_REQ);
      bus.mem_we    = op_store_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.mem_wstrb = wstrb_q;
   end

   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         state_q <= LSU_IDLE;
         tmo_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         fault_q <= fault_d;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         op_store_q <= 1'b0;
         op_f3_q    <= '0;
         lane_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rd_data_q  <= '0;
      end else begin
         if (accept) begin
            op_store_q <= is_store;
            op_f3_q    <= funct3;
            lane_q     <= ea[1:0];
            addr_q     <= {ea[31:2], 2'b00};
            wdata_q    <= st_wdata;
            wstrb_q    <= st_wstrb;
         end
         if (capture) begin
            rd_data_q <= ld_result;
         end
      end
   end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu: directed loads/stores, faults, timeout and reset abort.
module tb_rv32i_lsu;
   import rv32i_pkg::*;

   localparam int unsigned TMO = 4;

   typedef struct {
      logic        fault;
      logic        rd_we;
      logic [31:0] rd;
      int unsigned lat;
      int unsigned reqs;
      int unsigned t0;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } bus_t;

   logic        sys_clk = 1'b0;
   logic        sys_reset;
   logic        start, is_store;
   logic [2:0]  funct3;
   logic [31:0] base, offset, store_data;
   logic        busy, done, fault, rd_we;
   logic [31:0] rd_data;

   rv32i_lsu_if bus ();

   rv32i_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .sys_clk    (sys_clk),
      .sys_reset  (sys_reset),
      .start      (start),
      .is_store   (is_store),
      .funct3     (funct3),
      .base       (base),
      .offset     (offset),
      .store_data (store_data),
      .busy       (busy),
      .done       (done),
      .fault      (fault),
      .rd_we      (rd_we),
      .rd_data    (rd_data),
      .bus        (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   logic [31:0] last_rd = '0;
   exp_t exp_q[$];
   bus_t bus_q[$];

   always @(posedge sys_clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: compares bus fields every request cycle and the completion against the queue.
   int unsigned req_cnt = 0;
   logic        req_prev = 1'b0;
   bus_t        cur;
   exp_t        e;
   always @(negedge sys_clk) begin
      if (!sys_reset) begin
         req_cnt  = 0;
         req_prev = 1'b0;
      end else begin
         if (bus.mem_req) begin
            if (!req_prev) begin
               if (bus_q.size() == 0) chk("unexpected_req", 1, 0);
               else cur = bus_q.pop_front();
            end
            chk("mem_addr", bus.mem_addr, cur.addr);
            chk("mem_we", bus.mem_we, cur.we);
            chk("mem_wstrb", bus.mem_wstrb, cur.strb);
            chk("busy_in_req", busy, 1);
            if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
            req_cnt++;
         end
         req_prev = bus.mem_req;
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("fault", fault, e.fault);
               chk("rd_we", rd_we, e.rd_we);
               chk("rd_data", rd_data, e.rd);
               chk("latency", cyc - e.t0, e.lat);
               chk("req_cycles", req_cnt, e.reqs);
               chk("busy_in_done", busy, 1);
            end
            req_cnt = 0;
         end
      end
   end

   // mode 0: acked after ack_lat cycles, 1: fault at start, 2: timeout.
   task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] b, o, sd,
                        input int unsigned mode, input int unsigned ack_lat,
                        input logic [31:0] rdata, input logic [31:0] x_addr, x_wdata,
                        input logic [3:0] x_strb, input logic [31:0] x_rd, input bit poke);
      exp_t        ex;
      bus_t        bx;
      int unsigned k;
      int unsigned guard;
      ex.fault = (mode != 0);
      ex.rd_we = (mode == 0) && !st;
      ex.rd    = ex.rd_we ? x_rd : last_rd;
      last_rd  = ex.rd;
      ex.lat   = (mode == 0) ? ack_lat + 1 : (mode == 1) ? 1 : TMO + 1;
      ex.reqs  = (mode == 0) ? ack_lat : (mode == 1) ? 0 : TMO;
      ex.t0    = cyc;
      exp_q.push_back(ex);
      if (mode != 1) begin
         bx.addr = x_addr; bx.we = st; bx.wdata = x_wdata; bx.strb = x_strb;
         bus_q.push_back(bx);
      end
      is_store = st; funct3 = f3; base = b; offset = o; store_data = sd;
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      k = 1;
      if (poke && mode == 0 && ack_lat >= 2) begin
         start = 1'b1; is_store = ~st; funct3 = F3_W; base = '1; offset = '0;
         @(negedge sys_clk);
         start = 1'b0;
         k = 2;
      end
      if (mode == 0) begin
         while (k < ack_lat) begin
            @(negedge sys_clk);
            k++;
         end
         bus.mem_ack = 1'b1;
         bus.mem_rdata = rdata;
         @(negedge sys_clk);
         bus.mem_ack = 1'b0;
         bus.mem_rdata = 32'h5A5A_5A5A;
      end
      guard = 0;
      while (!done && guard < 300) begin
         @(negedge sys_clk);
         guard++;
      end
      if (!done) chk("done_timeout", 0, 1);
      @(negedge sys_clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of run, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sys_reset = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = '0;
      base = '0; offset = '0; store_data = '0;
      bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      repeat (2) @(negedge sys_clk);
      chk("reset_ctrl", {busy, done, fault, rd_we, bus.mem_req}, 5'b0);
      chk("reset_rd_data", rd_data, 32'h0);
      chk("reset_bus", {bus.mem_addr, bus.mem_wstrb}, 36'h0);
      #2 sys_reset = 1'b1;
      @(negedge sys_clk);

      // Spurious ack while idle must not start anything.
      bus.mem_ack = 1'b1;
      @(negedge sys_clk);
      bus.mem_ack = 1'b0;
      @(negedge sys_clk);
      chk("idle_ack_busy", busy, 0);

      do_op(0, F3_W,  32'h100, 32'h4, 0, 0, 1, 32'hDEAD_BEEF, 32'h104, 0, 4'b0000, 32'hDEAD_BEEF, 0);
      do_op(0, F3_B,  32'h100, 32'h3, 0, 0, 2, 32'h80FF_0000, 32'h100, 0, 4'b0000, 32'hFFFF_FF80, 1);
      do_op(0, F3_BU, 32'h100, 32'h3, 0, 0, 1, 32'h80FF_0000, 32'h100, 0, 4'b0000, 32'h0000_0080, 0);
      do_op(0, F3_H,  32'h100, 32'h2, 0, 0, 1, 32'h80FF_0000, 32'h100, 0, 4'b0000, 32'hFFFF_80FF, 0);
      do_op(0, F3_HU, 32'h200, 32'hFFFF_FFFE, 0, 0, 3, 32'h1234_ABCD, 32'h1FC, 0, 4'b0000, 32'h0000_1234, 1);
      do_op(1, F3_B,  32'h200, 32'h1, 32'h0000_00AB, 0, 1, 32'hFFFF_FFFF, 32'h200, 32'hABAB_ABAB, 4'b0010, 0, 0);
      do_op(1, F3_H,  32'h300, 32'h2, 32'h1234_CAFE, 0, 2, 0, 32'h300, 32'hCAFE_CAFE, 4'b1100, 0, 0);
      do_op(1, F3_W,  32'h400, 32'h0, 32'h0102_0304, 0, 1, 0, 32'h400, 32'h0102_0304, 4'b1111, 0, 0);
      do_op(0, F3_W,  32'h100, 32'h2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      do_op(0, 3'b011, 32'h100, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      do_op(1, F3_BU, 32'h400, 32'h0, 32'h55, 1, 0, 0, 0, 0, 0, 0, 0);
      do_op(1, F3_H,  32'h300, 32'h1, 32'h55, 1, 0, 0, 0, 0, 0, 0, 0);
      do_op(0, F3_W,  32'h500, 32'h0, 0, 2, 0, 0, 32'h500, 0, 4'b0000, 0, 0);

      // Reset asserted mid-request aborts the access without a completion.
      bus_q.push_back('{32'h600, 1'b0, 32'h0, 4'b0000});
      is_store = 1'b0; funct3 = F3_W; base = 32'h600; offset = 32'h0;
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      @(negedge sys_clk);
      chk("req_before_reset", bus.mem_req, 1);
      #2 sys_reset = 1'b0;
      #1;
      chk("reset_req_drop", {bus.mem_req, busy, done}, 3'b0);
      chk("reset_rd_clear", rd_data, 32'h0);
      last_rd = '0;
      @(negedge sys_clk);
      #2 sys_reset = 1'b1;
      @(negedge sys_clk);
      do_op(0, F3_W,  32'h600, 32'h0, 0, 0, 1, 32'h0BAD_F00D, 32'h600, 0, 4'b0000, 32'h0BAD_F00D, 0);

      repeat (3) @(negedge sys_clk);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("bus_q_drained", bus_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
